// File: rtl/seg7_value_display_if.sv
// Request/display bus between a value producer and the seven-segment display block.
// The producer drives load/mode/value; the display returns busy/done and the segment image.
interface seg7_value_display_if #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_DIGITS = 6
);
    logic                      load;
    logic                      mode;
    logic [WIDTH-1:0]          value;
    logic                      busy;
    logic                      done;
    logic [8*NUM_DIGITS-1:0]   hex_out;

    modport master (
        output load,
        output mode,
        output value,
        input  busy,
        input  done,
        input  hex_out
    );

    modport slave (
        input  load,
        input  mode,
        input  value,
        output busy,
        output done,
        output hex_out
    );
endinterface

// File: rtl/seg7_value_display.sv
// Latches a binary value and renders it on active-low seven-segment digits, in hex
// or in decimal via a sequential shift-add-3 converter. The display holds until an update.
module seg7_value_display #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned NUM_DIGITS    = 6,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    seg7_value_display_if.slave  bus
);
    localparam int unsigned BcdW = 4 * NUM_DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    function automatic int unsigned dec_digits(input int unsigned w);
        longint unsigned v;
        int unsigned     n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n++;
        end
        return n;
    endfunction

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("seg7_value_display: WIDTH must be in 1..32");
    end
    if (NUM_DIGITS < (WIDTH + 3) / 4 || NUM_DIGITS < dec_digits(WIDTH)) begin : g_bad_digits
        $error("seg7_value_display: NUM_DIGITS too small for WIDTH");
    end

    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    typedef enum logic [1:0] {StIdle, StConvert, StUpdate} state_e;

    state_e                  state_q;
    logic                    mode_q;
    logic [WIDTH-1:0]        shift_q;
    logic [BcdW-1:0]         bcd_q;
    logic [CntW-1:0]         cnt_q;
    logic                    busy_q;
    logic                    done_q;
    logic [8*NUM_DIGITS-1:0] hex_q;

    logic [BcdW-1:0]         bcd_adj;
    logic [BcdW-1:0]         digit_src;
    logic [8*NUM_DIGITS-1:0] hex_next;
    logic [3:0]              nib;
    logic                    seen;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                           : bcd_q[4*i +: 4];
        end
    end

    // Walk from the top digit down so blanking stops at the first nonzero digit.
    always_comb begin
        digit_src = '0;
        if (mode_q) begin
            digit_src = bcd_q;
        end else begin
            digit_src[WIDTH-1:0] = shift_q;
        end
        hex_next = '1;
        nib      = 4'h0;
        seen     = 1'b0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            nib  = digit_src[4*k +: 4];
            seen = seen | (nib != 4'h0);
            if (!BLANK_LEADING || seen || k == 0) begin
                hex_next[8*k +: 8] = seg7(nib);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hex_q   <= '1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.load) begin
                        mode_q  <= bus.mode;
                        shift_q <= bus.value;
                        bcd_q   <= '0;
                        cnt_q   <= CntW'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= bus.mode ? StConvert : StUpdate;
                    end
                end
                StConvert: begin
                    {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
                    cnt_q            <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StUpdate;
                    end
                end
                StUpdate: begin
                    hex_q   <= hex_next;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hex_out = hex_q;
endmodule

// File: tb/tb_seg7_value_display.sv
// Scoreboard bench: stimulus pushes expected displays and done cycles, a monitor checks them.
// Instance 0 blanks leading zeros, instance 1 shows all digits.
module tb_seg7_value_display;
    localparam int unsigned W  = 8;
    localparam int unsigned ND = 6;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic pd0, pd1;

    typedef struct {
        logic [8*ND-1:0] hex;
        int              cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    seg7_value_display_if #(.WIDTH(W), .NUM_DIGITS(ND)) bus0 ();
    seg7_value_display_if #(.WIDTH(W), .NUM_DIGITS(ND)) bus1 ();

    seg7_value_display #(.WIDTH(W), .NUM_DIGITS(ND), .BLANK_LEADING(1'b1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    seg7_value_display #(.WIDTH(W), .NUM_DIGITS(ND), .BLANK_LEADING(1'b0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [8*ND-1:0] act, input logic [8*ND-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic score(input int inst, input logic d, input logic pd, input logic [8*ND-1:0] h);
        exp_t e;
        string tag;
        tag = (inst == 0) ? "dut0" : "dut1";
        if (pd === 1'b1) check({tag, " done_width"}, {47'd0, d}, '0);
        if (d === 1'b1) begin
            if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected_done: got done=1, required no done (cycle %0d)",
                         tag, cyc);
            end else begin
                e = (inst == 0) ? q0.pop_front() : q1.pop_front();
                check({tag, " hex_out"}, h, e.hex);
                check({tag, " done_cycle"}, (8*ND)'(cyc), (8*ND)'(e.cyc));
            end
        end
    endtask

    always @(negedge clk) begin
        score(0, bus0.done, pd0, bus0.hex_out);
        score(1, bus1.done, pd1, bus1.hex_out);
        pd0 = bus0.done;
        pd1 = bus1.done;
    end

    // Drives a one-cycle load; if exp_on, queues the display and the cycle done must appear.
    task automatic issue(input int inst, input bit m, input logic [W-1:0] v, input bit exp_on,
                         input logic [8*ND-1:0] exp_hex);
        exp_t e;
        @(negedge clk);
        e.hex = exp_hex;
        e.cyc = cyc + (m ? int'(W) + 2 : 2);
        if (inst == 0) begin
            bus0.load = 1'b1; bus0.mode = m; bus0.value = v;
            if (exp_on) q0.push_back(e);
        end else begin
            bus1.load = 1'b1; bus1.mode = m; bus1.value = v;
            if (exp_on) q1.push_back(e);
        end
        @(negedge clk);
        bus0.load = 1'b0;
        bus1.load = 1'b0;
        if (exp_on) begin
            check("busy_after_load", {47'd0, (inst == 0) ? bus0.busy : bus1.busy}, 48'd1);
        end
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d/%0d pending, required 0 (cycle %0d)",
                     q0.size(), q1.size(), cyc);
            q0.delete();
            q1.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus0.load = 1'b0; bus0.mode = 1'b0; bus0.value = '0;
        bus1.load = 1'b0; bus1.mode = 1'b0; bus1.value = '0;

        // Reset state and idle hold
        repeat (2) @(negedge clk);
        check("reset_hex0", bus0.hex_out, 48'hFFFF_FFFF_FFFF);
        check("reset_hex1", bus1.hex_out, 48'hFFFF_FFFF_FFFF);
        check("reset_busy", {46'd0, bus0.busy, bus1.busy}, 48'd0);
        check("reset_done", {46'd0, bus0.done, bus1.done}, 48'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_hold", bus0.hex_out, 48'hFFFF_FFFF_FFFF);

        // Hex mode
        issue(0, 1'b0, 8'h35, 1'b1, 48'hFFFF_FFFF_B092);
        wait_empty(20);
        issue(1, 1'b0, 8'h35, 1'b1, 48'hC0C0_C0C0_B092);
        wait_empty(20);

        // Decimal mode
        issue(0, 1'b1, 8'd53, 1'b1, 48'hFFFF_FFFF_92B0);
        wait_empty(30);
        issue(0, 1'b1, 8'd255, 1'b1, 48'hFFFF_FFA4_9292);
        wait_empty(30);
        issue(0, 1'b1, 8'd0, 1'b1, 48'hFFFF_FFFF_FFC0);
        wait_empty(30);
        issue(1, 1'b1, 8'd0, 1'b1, 48'hC0C0_C0C0_C0C0);
        wait_empty(30);

        // Load while busy is ignored
        issue(0, 1'b1, 8'd200, 1'b1, 48'hFFFF_FFA4_C0C0);
        @(negedge clk);
        issue(0, 1'b0, 8'h0F, 1'b0, '0);
        wait_empty(30);
        repeat (5) @(negedge clk);
        check("busy_load_ignored", bus0.hex_out, 48'hFFFF_FFA4_C0C0);

        // Reset mid-conversion aborts with no done
        issue(0, 1'b1, 8'd123, 1'b0, '0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_hex", bus0.hex_out, 48'hFFFF_FFFF_FFFF);
        check("abort_busy", {47'd0, bus0.busy}, 48'd0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort_hold", bus0.hex_out, 48'hFFFF_FFFF_FFFF);
        issue(0, 1'b0, 8'hAB, 1'b1, 48'hFFFF_FFFF_8883);
        wait_empty(20);

        // Load in the done cycle is accepted
        issue(0, 1'b1, 8'd99, 1'b1, 48'hFFFF_FFFF_9090);
        repeat (W) @(negedge clk);
        issue(0, 1'b0, 8'h12, 1'b1, 48'hFFFF_FFFF_F9A4);
        wait_empty(30);
        repeat (3) @(negedge clk);
        check("b2b_final", bus0.hex_out, 48'hFFFF_FFFF_F9A4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
